// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types for the radix-2 Booth sequential multiplier
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth recoding of {Q[0], Q_1}
  typedef logic [1:0] booth_op_t;

  localparam booth_op_t OP_NOP0 = 2'b00;
  localparam booth_op_t OP_ADD  = 2'b01;
  localparam booth_op_t OP_SUB  = 2'b10;
  localparam booth_op_t OP_NOP1 = 2'b11;

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// rtl/booth_seq_multiplier_if.sv - request/result bundle of the Booth multiplier
interface booth_seq_multiplier_if #(
  parameter int WIDTH = 16
) ();

  logic                 start;
  logic                 abort;
  logic                 mode_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, abort, mode_signed, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, abort, mode_signed, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - FSM, iteration counter and datapath strobes
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic mode_signed,
  output logic load,
  output logic shift,
  output logic write_product,
  output logic busy,
  output logic done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load          = 1'b0;
    shift         = 1'b0;
    write_product = 1'b0;
    case (state_q)
      IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          load    = 1'b1;
          state_d = RUN;
          // unsigned needs one extra step to consume the zero-extended MSB
          cnt_d   = mode_signed ? CNT_W'(WIDTH - 1) : CNT_W'(WIDTH);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          shift = 1'b1;
          if (cnt_q == '0) begin
            write_product = 1'b1;
            state_d       = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);

endmodule

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - radix-2 Booth sequential multiplier, A/Q/Q_1/M datapath
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  booth_seq_multiplier_if.slave   bus
);

  logic                 load, shift, write_product;
  logic [WIDTH:0]       a_q, a_d, q_q, q_d, m_q, m_d;
  logic                 q1_q, q1_d;
  logic                 signed_q, signed_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH:0]       sum;
  booth_op_t            op;

  booth_seq_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .start         (bus.start),
    .abort         (bus.abort),
    .mode_signed   (bus.mode_signed),
    .load          (load),
    .shift         (shift),
    .write_product (write_product),
    .busy          (bus.busy),
    .done          (bus.done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      q1_q      <= 1'b0;
      signed_q  <= 1'b0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      q1_q      <= q1_d;
      signed_q  <= signed_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    q1_d      = q1_q;
    signed_d  = signed_q;
    product_d = product_q;
    op        = {q_q[0], q1_q};
    case (op)
      OP_ADD:  sum = a_q + m_q;
      OP_SUB:  sum = a_q - m_q;
      default: sum = a_q;
    endcase

    if (load) begin
      m_d      = bus.mode_signed ? {bus.multiplicand[WIDTH-1], bus.multiplicand}
                                 : {1'b0, bus.multiplicand};
      q_d      = bus.mode_signed ? {bus.multiplier[WIDTH-1], bus.multiplier}
                                 : {1'b0, bus.multiplier};
      a_d      = '0;
      q1_d     = 1'b0;
      signed_d = bus.mode_signed;
    end else if (shift) begin
      a_d  = {sum[WIDTH], sum[WIDTH:1]};
      q_d  = {sum[0], q_q[WIDTH:1]};
      q1_d = q_q[0];
      // signed runs one step short, so the unconsumed multiplier sign bit still sits in Q[0]
      if (write_product) begin
        product_d = signed_q ? {a_d[WIDTH-1:0], q_d[WIDTH:1]}
                             : {a_d[WIDTH-2:0], q_d};
      end
    end
  end

  assign bus.product = product_q;

endmodule
